// File: rtl/prog_clock_divider.sv
// prog_clock_divider: N_CH independent 50%-duty clock dividers with glitch-free shadowed divisor reload
module prog_clock_divider #(
  parameter int N_CH = 3,
  parameter int CNT_W = 32,
  parameter logic [N_CH*CNT_W-1:0] DIV_INIT = {32'd125000, 32'd25000000, 32'd50000000},
  localparam int LD_W = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync,
  input  logic              ld_valid,
  input  logic [LD_W-1:0]   ld_ch,
  input  logic [CNT_W-1:0]  ld_div,
  output logic              ld_ready,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick
);
  logic [CNT_W-1:0] cnt [N_CH];
  logic [CNT_W-1:0] act [N_CH];
  logic [CNT_W-1:0] shd [N_CH];
  logic [CNT_W-1:0] h [N_CH];
  logic [N_CH-1:0] pend, tc, hit;
  logic acc;
  always_comb begin
    ld_ready = 32'(ld_ch) < N_CH ? ~pend[ld_ch] : 1'b0;
    acc = ld_valid && ld_ready;
    for (int i = 0; i < N_CH; i++) begin
      h[i] = act[i] == '0 ? CNT_W'(1) : act[i];
      tc[i] = en && cnt[i] == h[i] - CNT_W'(1);
      hit[i] = acc && ld_ch == LD_W'(i);
    end
  end
  always_ff @(posedge sclk)
    for (int i = 0; i < N_CH; i++)
      if (rst) begin
        cnt[i] <= '0;
        clk_out[i] <= 1'b0;
        tick[i] <= 1'b0;
        pend[i] <= 1'b0;
        act[i] <= DIV_INIT[i*CNT_W +: CNT_W];
        shd[i] <= DIV_INIT[i*CNT_W +: CNT_W];
      end else if (sync) begin
        cnt[i] <= '0;
        clk_out[i] <= 1'b0;
        tick[i] <= 1'b0;
        pend[i] <= 1'b0;
        act[i] <= hit[i] ? ld_div : pend[i] ? shd[i] : act[i];
      end else begin
        tick[i] <= tc[i] && !clk_out[i];
        pend[i] <= hit[i] || (pend[i] && !tc[i]);
        if (hit[i]) shd[i] <= ld_div;
        if (tc[i] && pend[i]) act[i] <= shd[i];
        if (en) cnt[i] <= tc[i] ? '0 : cnt[i] + CNT_W'(1);
        if (tc[i]) clk_out[i] <= ~clk_out[i];
      end
endmodule

// File: tb/tb_prog_clock_divider.sv
// tb_prog_clock_divider: randomized and directed checks of prog_clock_divider against a remaining-cycles model
module tb_prog_clock_divider;
  localparam int N = 3;
  localparam int W = 8;
  logic sclk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic sync = 1'b0;
  logic ld_valid = 1'b0;
  logic [1:0] ld_ch = '0;
  logic [W-1:0] ld_div = '0;
  logic ld_ready;
  logic [N-1:0] clk_out, tick;
  int checks = 0;
  int errors = 0;
  int init [N] = '{4, 2, 1};
  int rem [N];
  int act [N];
  int shd [N];
  bit lvl [N];
  bit tk [N];
  bit pnd [N];
  always #5 sclk = ~sclk;
  prog_clock_divider #(.N_CH(N), .CNT_W(W), .DIV_INIT({8'd1, 8'd2, 8'd4})) dut (
    .sclk(sclk), .rst(rst), .en(en), .sync(sync), .ld_valid(ld_valid),
    .ld_ch(ld_ch), .ld_div(ld_div), .ld_ready(ld_ready), .clk_out(clk_out), .tick(tick)
  );
  function automatic int hm(int d);
    return d == 0 ? 1 : d;
  endfunction
  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(bit r, bit s, bit e, bit v, int c, int d);
    bit rdy, acc;
    rst = r;
    sync = s;
    en = e;
    ld_valid = v;
    ld_ch = 2'(c);
    ld_div = 8'(d);
    #1;
    rdy = (c < N) ? !pnd[c] : 1'b0;
    if (!r) chk("ld_ready", 8'(ld_ready), 8'(rdy));
    acc = v && rdy;
    @(posedge sclk);
    for (int i = 0; i < N; i++) begin
      if (r) begin
        act[i] = init[i];
        shd[i] = init[i];
        pnd[i] = 0;
        lvl[i] = 0;
        tk[i] = 0;
        rem[i] = hm(act[i]);
      end else if (s) begin
        act[i] = (acc && c == i) ? d : pnd[i] ? shd[i] : act[i];
        pnd[i] = 0;
        lvl[i] = 0;
        tk[i] = 0;
        rem[i] = hm(act[i]);
      end else begin
        tk[i] = 0;
        if (e) begin
          rem[i]--;
          if (rem[i] == 0) begin
            lvl[i] = !lvl[i];
            tk[i] = lvl[i];
            if (pnd[i]) begin
              act[i] = shd[i];
              pnd[i] = 0;
            end
            rem[i] = hm(act[i]);
          end
        end
        if (acc && c == i) begin
          shd[i] = d;
          pnd[i] = 1;
        end
      end
    end
    #1;
    chk("clk_out", 8'(clk_out), 8'({lvl[2], lvl[1], lvl[0]}));
    chk("tick", 8'(tick), 8'({tk[2], tk[1], tk[0]}));
  endtask
  initial begin
    int n;
    step(1, 0, 0, 0, 0, 0);
    chk("rst_clk_out", 8'(clk_out), 8'd0);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 0, 0);
    chk("rise_after_4", 8'(clk_out), 8'b001);
    for (int k = 0; k < 16; k++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 3);
    for (int k = 0; k < 20; k++) step(0, 0, 1, 0, 0, 0);
    n = 0;
    while (rem[1] != 1 && n < 20) begin
      step(0, 0, 1, 0, 0, 0);
      n++;
    end
    chk("ch1_tc_found", 8'(rem[1] == 1), 8'd1);
    step(0, 0, 1, 1, 1, 5);
    step(0, 0, 1, 1, 1, 7);
    for (int k = 0; k < 24; k++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 10; k++) step(0, 0, 0, k == 3, 2, 6);
    for (int k = 0; k < 6; k++) step(0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    chk("sync_clk_out", 8'(clk_out), 8'd0);
    for (int k = 0; k < 20; k++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 1, 3);
    step(1, 0, 1, 0, 0, 0);
    chk("rst_mid_clk_out", 8'(clk_out), 8'd0);
    step(0, 0, 1, 0, 1, 0);
    chk("rst_mid_ready", 8'(ld_ready), 8'd1);
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 150) == 0, $urandom_range(0, 30) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
